// File: rtl/reg_file.sv
// 2**ADDR_W x WIDTH register file: two combinational read ports, one write port on the rising clk edge; r0 reads 0.
// Zero-cycle read latency, no bypass (reads see the old value until the edge); no backpressure, every write is accepted.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [NREGS];

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we3 && (wa3 != '0)) begin
      regs[wa3] <= wd3;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file. It sits directly upstream of the ALU.
- Two asynchronous read ports drive the ALU `a` operand and the `b`-select path.
- One synchronous write port takes the writeback result (ALU `out` or load data).
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- ADDR_W, 5, address width; the number of registers is 2**ADDR_W.

Ports:
- clk  input  1  single system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears every register.
- ra1  input  ADDR_W  read address, port 1 (rs field).
- ra2  input  ADDR_W  read address, port 2 (rt field).
- rd1  output  WIDTH  read data, port 1; feeds ALU operand `a`.
- rd2  output  WIDTH  read data, port 2; feeds ALU operand `b` / store data.
- we3  input  1  write enable, sampled on the rising edge of clk.
- wa3  input  ADDR_W  write address (rd/rt destination).
- wd3  input  WIDTH  write data (ALU result or memory read data).

Behaviour:
- Storage: 2**ADDR_W registers of WIDTH bits. Entry 0 always reads 0, regardless of writes.
- Reset:
  - While reset=1, all registers are 0 immediately (asynchronous), so rd1=rd2=0 for any address.
  - Writes are ignored while reset=1.
  - Reset asserted mid-cycle between edges clears state at once; there is no wait for clk.
- Reset release:
  - The first write can take effect on the first rising edge where reset=0 and we3=1.
  - Reset deassertion coinciding with a clk edge is a system-level hazard; the bench keeps them apart.
- Write:
  - On posedge clk with reset=0, we3=1 and wa3!=0: reg[wa3] <= wd3.
  - wa3=0 with we3=1: no state change. The write is silently dropped; this is not an error.
  - we3=0: no state change, whatever wa3 and wd3 are.
- Read:
  - rd1 = (ra1==0) ? 0 : reg[ra1]. rd2 likewise for ra2.
  - Reads are purely combinational with zero-cycle latency; outputs track address changes within the same cycle.
- Read-during-write (same address, same cycle):
  - Before the edge, the read returns the OLD value.
  - After the edge, it returns the new value.
  - There is no internal write-to-read bypass; forwarding belongs to the hazard unit.
- Both read ports may address the same register simultaneously; both return the identical value.
- X handling: if we3 or wa3 is X at a clk edge, the result is undefined. The bench drives known values.
- Widths: no arithmetic is performed. Data passes through unmodified, with no sign or zero extension.
- Single write port: at most one register changes per clock edge.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then pulse reset for 3 ns between edges -> rd1 (ra1=5) reads 0x00000000 immediately, before any clk edge.
- Basic write/read: we3=1, wa3=7, wd3=0x12345678, one clk -> ra1=7 gives rd1=0x12345678; ra2=7 also gives 0x12345678. Then with we3=0, wd3=0xFFFFFFFF and another edge -> r7 is unchanged.
- r0 immutability: we3=1, wa3=0, wd3=0xFFFFFFFF, clk -> rd1 (ra1=0)=0 and rd2 (ra2=0)=0. Also check that no other register changed.
- Read-during-write: r3=0x00000011. Drive we3=1, wa3=3, wd3=0x00000022 with ra1=3 -> rd1=0x11 before the edge and 0x22 after it.
- Full sweep: write reg[i]=i*0x01010101 for i=1..31, then read every pair (ra1=i, ra2=31-i) -> each port returns its own register's value, and r0 returns 0.
- ALU integration: r1=5, r2=7, ALU in subtract mode fed from rd1/rd2 -> ALU output 0xFFFFFFFE and zero=0. Then r2=5 -> zero=1.
